// File: rtl/axi4_arb_pkg.sv
// Shared constants and FSM encoding for the 4-port AXI4 read arbiter.
package axi4_arb_pkg;

   localparam int NPORT        = 4;
   localparam int PIDX_W       = 2;
   localparam int MAX_OUTS_DEF = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/axi4_rd_arbiter_if.sv
// Bundle of the arbiter's AR and R channel signals; master is the arbiter's view,
// slave is the view of the requesters and the downstream memory.
interface axi4_rd_arbiter_if #(
   parameter int NPORT     = 4,
   parameter int AID_LEN   = 8,
   parameter int AADDR_LEN = 32,
   parameter int DATA_LEN  = 128
);

   logic [NPORT*(AID_LEN-2)-1:0] s_arid;
   logic [NPORT*AADDR_LEN-1:0]   s_araddr;
   logic [NPORT*8-1:0]           s_arlen;
   logic [NPORT-1:0]             s_arvalid;
   logic [NPORT-1:0]             s_arready;

   logic [AID_LEN-1:0]           m_arid;
   logic [AADDR_LEN-1:0]         m_araddr;
   logic [7:0]                   m_arlen;
   logic                         m_arvalid;
   logic                         m_arready;

   logic [AID_LEN-1:0]           m_rid;
   logic [DATA_LEN-1:0]          m_rdata;
   logic                         m_rlast;
   logic                         m_rvalid;
   logic                         m_rready;

   logic [AID_LEN-3:0]           s_rid;
   logic [DATA_LEN-1:0]          s_rdata;
   logic                         s_rlast;
   logic [NPORT-1:0]             s_rvalid;
   logic [NPORT-1:0]             s_rready;

   // Valid/ready: a transfer happens on a rising edge where both are high; once
   // valid is raised the payload holds until that edge.
   modport master (
      input  s_arid, s_araddr, s_arlen, s_arvalid, m_arready,
      input  m_rid, m_rdata, m_rlast, m_rvalid, s_rready,
      output s_arready, m_arid, m_araddr, m_arlen, m_arvalid,
      output m_rready, s_rid, s_rdata, s_rlast, s_rvalid
   );

   modport slave (
      output s_arid, s_araddr, s_arlen, s_arvalid, m_arready,
      output m_rid, m_rdata, m_rlast, m_rvalid, s_rready,
      input  s_arready, m_arid, m_araddr, m_arlen, m_arvalid,
      input  m_rready, s_rid, s_rdata, s_rlast, s_rvalid
   );

endinterface

// File: rtl/axi4_rr_pick.sv
// Combinational round-robin picker: first set mask bit after last_i, wrapping.
module axi4_rr_pick
   import axi4_arb_pkg::*;
(
   input  logic [NPORT-1:0]  mask_i,
   input  logic [PIDX_W-1:0] last_i,
   output logic [PIDX_W-1:0] grant_o,
   output logic              gvalid_o
);

   logic [PIDX_W-1:0] idx;

   always_comb begin
      grant_o  = '0;
      gvalid_o = 1'b0;
      idx      = '0;
      // NPORT is a power of two, so the index add wraps naturally.
      for (int k = 1; k <= NPORT; k++) begin
         idx = last_i + PIDX_W'(k);
         if (!gvalid_o && mask_i[idx]) begin
            grant_o  = idx;
            gvalid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Four-port AXI4 read-address arbiter with per-port outstanding-burst limits and
// ID-based combinational routing of the returning R channel.
module axi4_rd_arbiter #(
   parameter int NPORT     = axi4_arb_pkg::NPORT,
   parameter int AID_LEN   = 8,
   parameter int AADDR_LEN = 32,
   parameter int DATA_LEN  = 128,
   parameter int MAX_OUTS  = axi4_arb_pkg::MAX_OUTS_DEF
) (
   input  logic                         aclk_i,
   input  logic                         arst_i,
   input  logic [NPORT*(AID_LEN-2)-1:0] s_arid_i,
   input  logic [NPORT*AADDR_LEN-1:0]   s_araddr_i,
   input  logic [NPORT*8-1:0]           s_arlen_i,
   input  logic [NPORT-1:0]             s_arvalid_i,
   output logic [NPORT-1:0]             s_arready_o,
   output logic [AID_LEN-1:0]           m_arid_o,
   output logic [AADDR_LEN-1:0]         m_araddr_o,
   output logic [7:0]                   m_arlen_o,
   output logic                         m_arvalid_o,
   input  logic                         m_arready_i,
   input  logic [AID_LEN-1:0]           m_rid_i,
   input  logic [DATA_LEN-1:0]          m_rdata_i,
   input  logic                         m_rlast_i,
   input  logic                         m_rvalid_i,
   output logic                         m_rready_o,
   output logic [AID_LEN-3:0]           s_rid_o,
   output logic [DATA_LEN-1:0]          s_rdata_o,
   output logic                         s_rlast_o,
   output logic [NPORT-1:0]             s_rvalid_o,
   input  logic [NPORT-1:0]             s_rready_i,
   output logic                         rd_err_o,
   output axi4_arb_pkg::arb_state_e     dbg_state_o
);

   import axi4_arb_pkg::*;

   localparam int UID_W = AID_LEN - 2;
   localparam int CNT_W = $clog2(MAX_OUTS + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   arb_state_e           state_q, state_d;
   logic [PIDX_W-1:0]    last_q, last_d;
   logic [AID_LEN-1:0]   arid_q, arid_d;
   logic [AADDR_LEN-1:0] araddr_q, araddr_d;
   logic [7:0]           arlen_q, arlen_d;
   logic                 arvalid_q, arvalid_d;
   logic [NPORT-1:0]     sready_q, sready_d;
   logic                 err_q, err_d;
   cnt_t                 outs_q [NPORT];
   cnt_t                 outs_d [NPORT];

   logic [NPORT-1:0]     elig;
   logic [PIDX_W-1:0]    gnt_idx;
   logic                 gnt_vld;
   logic                 grant;
   logic [PIDX_W-1:0]    r_port;
   logic                 r_done;
   logic [NPORT-1:0]     inc_v, dec_v;

   // R channel: the top ID bits name the requester that owns the beat.
   assign r_port     = m_rid_i[AID_LEN-1 -: PIDX_W];
   assign m_rready_o = s_rready_i[r_port];
   assign s_rvalid_o = NPORT'(m_rvalid_i) << r_port;
   assign s_rid_o    = m_rid_i[UID_W-1:0];
   assign s_rdata_o  = m_rdata_i;
   assign s_rlast_o  = m_rlast_i;
   assign r_done     = m_rvalid_i & m_rready_o & m_rlast_i;

   always_comb begin
      elig = '0;
      for (int p = 0; p < NPORT; p++) begin
         elig[p] = (state_q == ST_IDLE) && s_arvalid_i[p] &&
                   (outs_q[p] != cnt_t'(MAX_OUTS));
      end
   end

   axi4_rr_pick u_pick (
      .mask_i   (elig),
      .last_i   (last_q),
      .grant_o  (gnt_idx),
      .gvalid_o (gnt_vld)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arvalid_d = arvalid_q;
      sready_d  = '0;
      grant     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               grant             = 1'b1;
               state_d           = ST_ISSUE;
               last_d            = gnt_idx;
               arid_d            = {gnt_idx, s_arid_i[gnt_idx*UID_W +: UID_W]};
               araddr_d          = s_araddr_i[gnt_idx*AADDR_LEN +: AADDR_LEN];
               arlen_d           = s_arlen_i[gnt_idx*8 +: 8];
               arvalid_d         = 1'b1;
               sready_d[gnt_idx] = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (m_arready_i) begin
               arvalid_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      inc_v = '0;
      dec_v = '0;
      if (grant)  inc_v[gnt_idx] = 1'b1;
      if (r_done) dec_v[r_port]  = 1'b1;
   end

   // A grant and a final beat on the same port cancel out; a final beat on an
   // idle port is a protocol error and the count is held at zero.
   always_comb begin
      err_d = err_q;
      for (int p = 0; p < NPORT; p++) begin
         outs_d[p] = outs_q[p];
         if (inc_v[p] && !dec_v[p]) begin
            outs_d[p] = outs_q[p] + cnt_t'(1);
         end else if (dec_v[p] && !inc_v[p]) begin
            if (outs_q[p] == '0) err_d = 1'b1;
            else                 outs_d[p] = outs_q[p] - cnt_t'(1);
         end
      end
   end

   always_ff @(posedge aclk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q   <= ST_IDLE;
         last_q    <= PIDX_W'(NPORT - 1);
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arvalid_q <= 1'b0;
         sready_q  <= '0;
         err_q     <= 1'b0;
         for (int p = 0; p < NPORT; p++) outs_q[p] <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arvalid_q <= arvalid_d;
         sready_q  <= sready_d;
         err_q     <= err_d;
         for (int p = 0; p < NPORT; p++) outs_q[p] <= outs_d[p];
      end
   end

   assign s_arready_o = sready_q;
   assign m_arid_o    = arid_q;
   assign m_araddr_o  = araddr_q;
   assign m_arlen_o   = arlen_q;
   assign m_arvalid_o = arvalid_q;
   assign rd_err_o    = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Self-checking bench for axi4_rd_arbiter: directed scenarios plus randomized
// traffic against a grant/outstanding-count reference model.
module tb_axi4_rd_arbiter;

   localparam int NP   = 4;
   localparam int AIDW = 8;
   localparam int UIDW = 6;
   localparam int AW   = 32;
   localparam int DW   = 128;
   localparam int MAXO = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   axi4_rd_arbiter_if #(.NPORT(NP), .AID_LEN(AIDW), .AADDR_LEN(AW), .DATA_LEN(DW)) bus ();
   logic                     rd_err;
   axi4_arb_pkg::arb_state_e dbg_state;

   axi4_rd_arbiter #(
      .NPORT(NP), .AID_LEN(AIDW), .AADDR_LEN(AW), .DATA_LEN(DW), .MAX_OUTS(MAXO)
   ) dut (
      .aclk_i      (clk),
      .arst_i      (rst),
      .s_arid_i    (bus.s_arid),
      .s_araddr_i  (bus.s_araddr),
      .s_arlen_i   (bus.s_arlen),
      .s_arvalid_i (bus.s_arvalid),
      .s_arready_o (bus.s_arready),
      .m_arid_o    (bus.m_arid),
      .m_araddr_o  (bus.m_araddr),
      .m_arlen_o   (bus.m_arlen),
      .m_arvalid_o (bus.m_arvalid),
      .m_arready_i (bus.m_arready),
      .m_rid_i     (bus.m_rid),
      .m_rdata_i   (bus.m_rdata),
      .m_rlast_i   (bus.m_rlast),
      .m_rvalid_i  (bus.m_rvalid),
      .m_rready_o  (bus.m_rready),
      .s_rid_o     (bus.s_rid),
      .s_rdata_o   (bus.s_rdata),
      .s_rlast_o   (bus.s_rlast),
      .s_rvalid_o  (bus.s_rvalid),
      .s_rready_i  (bus.s_rready),
      .rd_err_o    (rd_err),
      .dbg_state_o (dbg_state)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // stimulus values for the next cycle, and the copy the next edge will see
   logic [NP-1:0]   d_valid, p_valid;
   logic            d_arready, p_arready;
   logic [UIDW-1:0] d_id [NP];
   logic [UIDW-1:0] p_id [NP];
   logic [AW-1:0]   d_addr [NP];
   logic [AW-1:0]   p_addr [NP];
   logic [7:0]      d_len [NP];
   logic [7:0]      p_len [NP];
   logic            d_rvalid, p_rvalid, d_rlast, p_rlast;
   logic [AIDW-1:0] d_rid, p_rid;
   logic [DW-1:0]   d_rdata;
   logic [NP-1:0]   d_rready, p_rready;

   // reference model: outstanding bursts per port, last winner, pending AR
   int            m_outs [NP];
   int            m_last;
   bit            m_pend;
   bit            m_err;
   logic [AIDW-1:0] e_id;
   logic [AW-1:0]   e_addr;
   logic [7:0]      e_len;
   int            grants_q[$];
   int            gcyc_q[$];
   logic [1:0]    exp_q[$];
   int            cyc = 0;

   task automatic model_reset();
      for (int p = 0; p < NP; p++) m_outs[p] = 0;
      m_last = NP - 1;
      m_pend = 0;
      m_err  = 0;
      e_id   = '0;
      e_addr = '0;
      e_len  = '0;
   endtask

   // driver: apply stimulus, then check the combinational R routing
   task automatic drive();
      logic [1:0] rp;
      for (int p = 0; p < NP; p++) begin
         bus.s_arid[p*UIDW +: UIDW] = d_id[p];
         bus.s_araddr[p*AW +: AW]   = d_addr[p];
         bus.s_arlen[p*8 +: 8]      = d_len[p];
         p_id[p]   = d_id[p];
         p_addr[p] = d_addr[p];
         p_len[p]  = d_len[p];
      end
      bus.s_arvalid = d_valid;
      bus.m_arready = d_arready;
      bus.m_rvalid  = d_rvalid;
      bus.m_rid     = d_rid;
      bus.m_rdata   = d_rdata;
      bus.m_rlast   = d_rlast;
      bus.s_rready  = d_rready;
      p_valid = d_valid;  p_arready = d_arready;
      p_rvalid = d_rvalid; p_rlast = d_rlast; p_rid = d_rid; p_rready = d_rready;
      #1;
      rp = d_rid[7:6];
      check("s_rvalid", bus.s_rvalid, d_rvalid ? (4'b0001 << rp) : 4'b0000);
      check("m_rready", bus.m_rready, d_rready[rp]);
      check("s_rid",    bus.s_rid, d_rid[5:0]);
      check("s_rdata",  bus.s_rdata, d_rdata);
      check("s_rlast",  bus.s_rlast, d_rlast);
   endtask

   // one clock: advance the model over the edge, then compare registered outputs
   task automatic tick();
      bit eg;
      int gp;
      int rp;
      @(negedge clk);
      cyc++;
      eg = 0;
      gp = 0;
      if (!m_pend) begin
         for (int k = 1; k <= NP; k++) begin
            int p;
            p = (m_last + k) % NP;
            if (!eg && p_valid[p] && m_outs[p] < MAXO) begin
               eg = 1;
               gp = p;
            end
         end
      end else if (p_arready) begin
         m_pend = 0;
      end
      if (eg) begin
         m_pend = 1;
         m_outs[gp]++;
         m_last = gp;
         e_id   = {2'(gp), p_id[gp]};
         e_addr = p_addr[gp];
         e_len  = p_len[gp];
         grants_q.push_back(gp);
         gcyc_q.push_back(cyc);
      end
      rp = int'(p_rid[7:6]);
      if (p_rvalid && p_rlast && p_rready[rp]) begin
         if (m_outs[rp] == 0) m_err = 1;
         else                 m_outs[rp]--;
      end
      check("s_arready", bus.s_arready, eg ? (4'b0001 << gp) : 4'b0000);
      check("m_arvalid", bus.m_arvalid, m_pend);
      if (m_pend) begin
         check("m_arid",   bus.m_arid, e_id);
         check("m_araddr", bus.m_araddr, e_addr);
         check("m_arlen",  bus.m_arlen, e_len);
      end
      check("rd_err", rd_err, m_err);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive();
         tick();
      end
   endtask

   task automatic idle_inputs();
      d_valid = '0; d_arready = 1'b1;
      for (int p = 0; p < NP; p++) begin
         d_id[p]   = UIDW'(p + 1);
         d_addr[p] = 32'h100 * (p + 1);
         d_len[p]  = 8'(p * 2 + 1);
      end
      d_rvalid = 0; d_rlast = 0; d_rid = '0; d_rdata = '0; d_rready = '1;
   endtask

   // return one final beat per outstanding burst
   task automatic drain();
      d_valid = '0;
      d_arready = 1'b1;
      run(2);
      for (int p = 0; p < NP; p++) begin
         while (m_outs[p] > 0) begin
            d_rvalid = 1; d_rlast = 1; d_rready = '1;
            d_rid    = {2'(p), 6'($urandom_range(0, 63))};
            d_rdata  = {$urandom, $urandom, $urandom, $urandom};
            run(1);
         end
      end
      d_rvalid = 0; d_rlast = 0;
      run(1);
   endtask

   function automatic int count_port(input int p);
      int n;
      n = 0;
      foreach (grants_q[i]) if (grants_q[i] == p) n++;
      return n;
   endfunction

   initial begin
      int c0;
      idle_inputs();
      model_reset();
      drive();
      repeat (2) @(negedge clk);

      // reset state
      check("rst_m_arvalid", bus.m_arvalid, 1'b0);
      check("rst_s_arready", bus.s_arready, 4'b0000);
      check("rst_m_araddr",  bus.m_araddr, 32'h0);
      check("rst_m_arlen",   bus.m_arlen, 8'h0);
      check("rst_m_arid",    bus.m_arid, 8'h0);
      check("rst_rd_err",    rd_err, 1'b0);
      check("rst_state",     dbg_state, axi4_arb_pkg::ST_IDLE);
      rst = 1'b0;

      // all ports requesting, downstream always ready
      grants_q.delete(); gcyc_q.delete();
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      exp_q.push_back(2'd3); exp_q.push_back(2'd0);
      d_valid = '1; d_arready = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 12 && grants_q.size() < 5; i++) run(1);
      check("rr_count", grants_q.size(), 5);
      check("rr_latency", (gcyc_q.size() > 0) ? gcyc_q[0] - c0 : -1, 1);
      for (int i = 0; i < 5 && i < grants_q.size(); i++) begin
         check("rr_order", grants_q[i], exp_q[i]);
         if (i > 0) check("rr_spacing", gcyc_q[i] - gcyc_q[i-1], 2);
      end
      drain();

      // port 2 saturates while port 1 keeps flowing; one final beat frees port 2
      grants_q.delete();
      d_valid = 4'b0100;
      run(14);
      check("p2_fill", count_port(2), MAXO);
      grants_q.delete();
      d_valid = 4'b0110;
      run(14);
      check("p2_blocked", count_port(2), 0);
      check("p1_flows",   count_port(1), MAXO);
      grants_q.delete();
      d_valid = 4'b0100;
      d_rvalid = 1; d_rlast = 1; d_rready = '1; d_rid = 8'h80;
      run(1);
      d_rvalid = 0; d_rlast = 0;
      run(6);
      check("p2_reenabled", count_port(2), 1);
      drain();

      // downstream stalls for 10 cycles
      grants_q.delete();
      d_valid = 4'b0001; d_addr[0] = 32'h0000_1000; d_len[0] = 8'd15; d_arready = 1'b0;
      run(1);
      for (int i = 0; i < 10; i++) begin
         run(1);
         check("stall_arvalid", bus.m_arvalid, 1'b1);
         check("stall_araddr",  bus.m_araddr, 32'h0000_1000);
         check("stall_arlen",   bus.m_arlen, 8'd15);
         check("stall_arready", bus.s_arready, 4'b0000);
      end
      check("stall_grants", grants_q.size(), 1);
      drain();

      // R beat to port 3 with port 3 not ready
      d_rvalid = 1; d_rid = 8'hC5; d_rready = 4'b0111; d_rlast = 1;
      d_rdata = {$urandom, $urandom, $urandom, $urandom};
      drive();
      check("route_s_rvalid", bus.s_rvalid, 4'b1000);
      check("route_m_rready", bus.m_rready, 1'b0);
      check("route_s_rid",    bus.s_rid, 6'h05);
      tick();
      d_rvalid = 0; d_rlast = 0; d_rready = '1;

      // final beat to a port with nothing outstanding
      d_rvalid = 1; d_rlast = 1; d_rid = 8'h51;
      run(1);
      check("err_set", rd_err, 1'b1);
      d_rvalid = 0; d_rlast = 0;
      run(5);
      check("err_sticky", rd_err, 1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         int rp;
         d_arready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) d_valid = 4'($urandom_range(0, 15));
         for (int p = 0; p < NP; p++) begin
            d_id[p]   = 6'($urandom);
            d_addr[p] = $urandom;
            d_len[p]  = 8'($urandom);
         end
         d_rvalid = ($urandom_range(0, 1) == 1);
         rp       = $urandom_range(0, NP - 1);
         d_rid    = {2'(rp), 6'($urandom)};
         d_rlast  = ($urandom_range(0, 1) == 1) && (m_outs[rp] > 0);
         d_rready = 4'($urandom);
         d_rdata  = {$urandom, $urandom, $urandom, $urandom};
         run(1);
      end
      drain();

      // asynchronous reset while a request is pending downstream
      d_valid = 4'b0001; d_arready = 1'b0;
      run(2);
      #2 rst = 1'b1;
      #1;
      check("arst_m_arvalid", bus.m_arvalid, 1'b0);
      check("arst_s_arready", bus.s_arready, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      grants_q.delete();
      d_valid = '1; d_arready = 1'b1;
      run(1);
      check("arst_first_cnt", grants_q.size(), 1);
      check("arst_first_port", (grants_q.size() > 0) ? grants_q[0] : -1, 0);
      check("arst_first_id_port", bus.m_arid[7:6], 2'd0);
      d_valid = '0;
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
